// File: rtl/regwrite_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regwrite_arbiter_pkg
//   Shared definitions for the register-file write-port arbiter.
//   Contents:
//     REG_ADDR_W / REG_DATA_W  register file address / data widths
//     ZERO_REG                 hard-wired zero register (writes suppressed)
//     GRANT_ID_W               width of the grant_id output
//     WAIT_CNT_W               width of the per-requester wait counters
//     pri_mode_e               priority_mode encoding
//     rr_next()                round-robin pointer successor with wrap
// ---------------------------------------------------------------------------
package regwrite_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int ZERO_REG   = 0;
  localparam int GRANT_ID_W = 3;
  // Wide enough for the largest permitted starvation limit (255).
  localparam int WAIT_CNT_W = 8;

  typedef enum logic {
    PRI_FIXED = 1'b0,
    PRI_RR    = 1'b1
  } pri_mode_e;

  // Index following idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regwrite_arbiter_if.sv
// ---------------------------------------------------------------------------
// regwrite_arbiter_if
//   Bundles the requester handshake and the register-file write port.
//   Signals:
//     req_valid  [NUM_REQ]         per-requester write request
//     req_addr   [NUM_REQ*ADDR_W]  packed destination registers
//     req_data   [NUM_REQ*DATA_W]  packed write data
//     req_ready  [NUM_REQ]         one-hot grant (transfer on valid & ready)
//     RegWrite                     register file write enable
//     WriteReg   [ADDR_W]          register file write address
//     WriteData  [DATA_W]          register file write data
//     grant_id   [3]               index of last accepted requester
//   Modports:
//     master  requester / register-file side
//     slave   arbiter side
// ---------------------------------------------------------------------------
interface regwrite_arbiter_if
  import regwrite_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      RegWrite;
  logic [ADDR_W-1:0]         WriteReg;
  logic [DATA_W-1:0]         WriteData;
  logic [GRANT_ID_W-1:0]     grant_id;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, RegWrite, WriteReg, WriteData, grant_id
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, RegWrite, WriteReg, WriteData, grant_id
  );

endinterface

// File: rtl/regwrite_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Rotating-priority picker: scans the request vector starting at i_start,
//   wrapping modulo N, and returns the first set bit. A fixed lowest-index
//   picker is simply i_start = 0.
//   Ports:
//     i_req    [N]      request vector
//     i_start  [IDX_W]  index with highest priority (must be < N)
//     o_grant  [N]      one-hot grant (zero when no request)
//     o_idx    [IDX_W]  index of the granted bit
//     o_any    1        at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = IDX_W'((int'(i_start) + k) % N);
      // o_any latches the first hit so later positions cannot override it.
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/regwrite_arbiter.sv
// ---------------------------------------------------------------------------
// regwrite_arbiter
//   Shares the single register-file write port between NUM_REQ writeback
//   sources (ALU, load unit, multiplier, ...). One write is granted per
//   cycle, by fixed priority (index 0 highest) or round-robin. A requester
//   that has waited STARVE_LIMIT cycles is forced through ahead of both.
//   Accepted writes appear on the write port one cycle later; writes to
//   the zero register are accepted but not enabled.
//   Ports:
//     CLK            clock, all state on posedge
//     reset          synchronous active-low reset
//     priority_mode  0 = fixed priority, 1 = round-robin
//     bus            regwrite_arbiter_if.slave (requests + write port)
// ---------------------------------------------------------------------------
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = REG_ADDR_W,
  parameter int DATA_W       = REG_DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              priority_mode,
  regwrite_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(STARVE_LIMIT);

  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_regwrite;
  logic [ADDR_W-1:0]  r_write_reg;
  logic [DATA_W-1:0]  r_write_data;
  logic [GRANT_ID_W-1:0] r_grant_id;

  logic [NUM_REQ-1:0] w_starved;
  logic [NUM_REQ-1:0] w_norm_grant;
  logic [NUM_REQ-1:0] w_starve_grant;
  logic [NUM_REQ-1:0] w_ready;
  logic [IDX_W-1:0]   w_norm_idx;
  logic [IDX_W-1:0]   w_starve_idx;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [IDX_W-1:0]   w_start;
  logic               w_norm_any;
  logic               w_starve_any;
  logic               w_forced;
  logic               w_accept;
  logic [ADDR_W-1:0]  w_addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  w_data_arr [NUM_REQ];
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;

  // Per-requester wait counters and unpacking of the address/data buses.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic [WAIT_CNT_W-1:0] r_wait;

    // Qualified with valid so a starved slot can never raise ready alone.
    assign w_starved[gi]  = bus.req_valid[gi] && (r_wait == LIMIT);
    assign w_addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
    assign w_data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];

    always_ff @(posedge CLK) begin
      if (!reset) begin
        r_wait <= '0;
      end else if (!bus.req_valid[gi] || w_ready[gi]) begin
        r_wait <= '0;
      end else if (r_wait != LIMIT) begin
        r_wait <= r_wait + WAIT_CNT_W'(1);
      end
    end
  end

  // Fixed-priority mode is the round-robin picker pinned to start 0.
  assign w_start = (priority_mode == PRI_RR) ? r_rr_ptr : '0;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_norm_pick (
    .i_req   (bus.req_valid),
    .i_start (w_start),
    .o_grant (w_norm_grant),
    .o_idx   (w_norm_idx),
    .o_any   (w_norm_any)
  );

  // Starved requesters are served lowest index first.
  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_starve_pick (
    .i_req   (w_starved),
    .i_start ('0),
    .o_grant (w_starve_grant),
    .o_idx   (w_starve_idx),
    .o_any   (w_starve_any)
  );

  always_comb begin
    w_ready     = '0;
    w_grant_idx = '0;
    w_forced    = 1'b0;
    // No grant while reset is asserted, so nothing is accepted then.
    if (reset) begin
      if (w_starve_any) begin
        w_ready     = w_starve_grant;
        w_grant_idx = w_starve_idx;
        w_forced    = 1'b1;
      end else if (w_norm_any) begin
        w_ready     = w_norm_grant;
        w_grant_idx = w_norm_idx;
      end
    end
  end

  assign w_accept   = |(w_ready & bus.req_valid);
  assign w_sel_addr = w_addr_arr[w_grant_idx];
  assign w_sel_data = w_data_arr[w_grant_idx];

  // Only normal round-robin grants advance the pointer; forced and
  // fixed-priority grants leave the rotation where it was.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_rr_ptr <= '0;
    end else if (w_accept && !w_forced && (priority_mode == PRI_RR)) begin
      r_rr_ptr <= IDX_W'(rr_next(int'(w_grant_idx), NUM_REQ));
    end
  end

  // Write port: one cycle after accept. Address/data/id hold when idle.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_regwrite   <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_grant_id   <= '0;
    end else if (w_accept) begin
      r_regwrite   <= (w_sel_addr != ADDR_W'(ZERO_REG));
      r_write_reg  <= w_sel_addr;
      r_write_data <= w_sel_data;
      r_grant_id   <= GRANT_ID_W'(w_grant_idx);
    end else begin
      r_regwrite   <= 1'b0;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.RegWrite  = r_regwrite;
  assign bus.WriteReg  = r_write_reg;
  assign bus.WriteData = r_write_data;
  assign bus.grant_id  = r_grant_id;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regwrite_arbiter
//   Directed testbench for regwrite_arbiter with NUM_REQ=4, STARVE_LIMIT=3.
//   Inputs change 1 time unit after the rising edge; ready is sampled after
//   the inputs settle, registered outputs 1 time unit after the next edge.
// ---------------------------------------------------------------------------
module tb_regwrite_arbiter;
  import regwrite_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SL = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic pmode;

  always #5 clk = ~clk;

  regwrite_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  regwrite_arbiter #(
    .NUM_REQ      (NR),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (SL)
  ) dut (
    .CLK           (clk),
    .reset         (rst_n),
    .priority_mode (pmode),
    .bus           (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input int a, input int d);
    bus.req_addr[i*AW +: AW] = AW'(a);
    bus.req_data[i*DW +: DW] = DW'(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string tag, input int we, input int wr, input int wd, input int gid);
    check({tag, "_regwrite"},  64'(bus.RegWrite),  64'(we));
    check({tag, "_writereg"},  64'(bus.WriteReg),  64'(wr));
    check({tag, "_writedata"}, 64'(bus.WriteData), 64'(wd));
    check({tag, "_grant_id"},  64'(bus.grant_id),  64'(gid));
  endtask

  int exp_rr [5] = '{0, 1, 2, 3, 0};
  int exp_st [5] = '{0, 0, 0, 3, 0};

  initial begin
    rst_n = 1'b0;
    pmode = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NR; i++) set_req(i, i + 1, 16 * (i + 1));
    #1;

    // 1. reset held for two cycles with every requester valid
    for (int c = 0; c < 2; c++) begin
      check("rst_ready", 64'(bus.req_ready), 64'(0));
      tick();
      check_port("rst", 0, 0, 0, 0);
    end
    rst_n = 1'b1;
    bus.req_valid = 4'b0000;
    tick();
    check("idle_regwrite", 64'(bus.RegWrite), 64'(0));

    // 2. fixed priority, r1 then r2
    set_req(1, 5, 25);
    set_req(2, 10, 100);
    bus.req_valid = 4'b0110;
    #1 check("fix_ready_r1", 64'(bus.req_ready), 64'(4'b0010));
    tick();
    check_port("fix_r1", 1, 5, 25, 1);
    bus.req_valid = 4'b0100;
    #1 check("fix_ready_r2", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    check_port("fix_r2", 1, 10, 100, 2);
    bus.req_valid = 4'b0000;
    tick();
    check("fix_idle_regwrite", 64'(bus.RegWrite), 64'(0));
    check("fix_idle_hold_reg", 64'(bus.WriteReg), 64'(10));

    // 3. round-robin, all four valid: 0,1,2,3,0
    pmode = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, i + 1, 16 * (i + 1));
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("rr_ready_%0d", k), 64'(bus.req_ready), 64'(1) << exp_rr[k]);
      tick();
      check($sformatf("rr_gid_%0d", k), 64'(bus.grant_id), 64'(exp_rr[k]));
      check($sformatf("rr_reg_%0d", k), 64'(bus.WriteReg), 64'(exp_rr[k] + 1));
    end
    bus.req_valid = 4'b0000;
    tick();

    // 4. fixed priority starvation guard: r3 forced on the 4th cycle
    pmode = 1'b0;
    bus.req_valid = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("starve_ready_%0d", k), 64'(bus.req_ready), 64'(1) << exp_st[k]);
      tick();
      check($sformatf("starve_gid_%0d", k), 64'(bus.grant_id), 64'(exp_st[k]));
    end
    bus.req_valid = 4'b0000;
    tick();

    // 5. write to register 0 is accepted but not enabled
    set_req(2, 0, 32'hDEAD);
    bus.req_valid = 4'b0100;
    #1 check("zero_ready", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    check_port("zero", 0, 0, 32'hDEAD, 2);
    bus.req_valid = 4'b0000;
    tick();

    // 6. rr_ptr returns to 0 on reset
    pmode = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, i + 1, 16 * (i + 1));
    bus.req_valid = 4'b0010;
    #1 check("ptr_ready_r1", 64'(bus.req_ready), 64'(4'b0010));
    tick();
    bus.req_valid = 4'b1100;
    rst_n = 1'b0;
    #1 check("ptr_rst_ready", 64'(bus.req_ready), 64'(0));
    tick();
    check_port("ptr_rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    #1 check("ptr_after_rst_r2", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    check_port("ptr_after_rst", 1, 3, 48, 2);

    // pointer to 2 again, reset, then a vector that separates ptr 0 from 2
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'b1010;
    #1 check("ptr_zero_sel", 64'(bus.req_ready), 64'(4'b0010));
    tick();
    // pointer now 2: round-robin picks r3, fixed picks r1 in the same cycle
    #1 check("rr_after_r1", 64'(bus.req_ready), 64'(4'b1000));
    pmode = 1'b0;
    #1 check("mode_switch", 64'(bus.req_ready), 64'(4'b0010));
    bus.req_valid = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
